// File: rtl/turn_select_ctrl.sv
// rtl/turn_select_ctrl.sv - turn/cursor controller gating the Selector and committing cell choices
// Optional idle auto-commit is built when TURN_TIMEOUT_EN is defined.
module turn_select_ctrl #(
  parameter int N_OPTIONS      = 9,
  parameter int N_PLAYERS      = 2,
  parameter int TIMEOUT_CYCLES = 500,
  localparam int CW = (N_OPTIONS > 2) ? $clog2(N_OPTIONS) : 1,
  localparam int PW = (N_PLAYERS > 2) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 next_in,
  input  logic                 select_in,
  input  logic [N_OPTIONS-1:0] avail_mask,
  input  logic                 ack,
  output logic                 sel_enable,
  output logic [CW-1:0]        cursor,
  output logic [PW-1:0]        player,
  output logic                 choice_valid,
  output logic [CW-1:0]        choice,
  output logic [PW-1:0]        choice_player,
  output logic                 no_moves
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BROWSE = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state;
  logic          next_q;
  logic          select_q;
  logic          seek;
  logic          in_browse;
  logic          nxt_e;
  logic          sel_e;
  logic          take;
  logic          timeout_hit;
  logic          low_found;
  logic [CW-1:0] low_idx;
  logic [CW-1:0] nxt_idx;
  logic [CW-1:0] cand;

  // seek marks the first BROWSE cycle after ack, when the board's updated mask is sampled
  assign in_browse  = (state == S_BROWSE) && !seek;
  assign nxt_e      = next_in & ~next_q & in_browse;
  assign sel_e      = select_in & ~select_q & in_browse;
  assign take       = (sel_e | timeout_hit) & avail_mask[cursor];
  assign sel_enable = (state == S_BROWSE);
  assign no_moves   = (state == S_DONE);

  always_comb begin
    low_found = 1'b0;
    low_idx   = '0;
    for (int i = N_OPTIONS - 1; i >= 0; i--) begin
      if (avail_mask[i]) begin
        low_found = 1'b1;
        low_idx   = CW'(i);
      end
    end
  end

  // Descending scan so the nearest free cell above the cursor (with wrap) wins
  always_comb begin
    nxt_idx = cursor;
    cand    = '0;
    for (int k = N_OPTIONS - 1; k >= 1; k--) begin
      cand = CW'((int'(cursor) + k) % N_OPTIONS);
      if (avail_mask[cand]) nxt_idx = cand;
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = in_browse && !nxt_e && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (abort || !in_browse || nxt_e || take) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      cursor        <= '0;
      player        <= '0;
      choice        <= '0;
      choice_player <= '0;
      choice_valid  <= 1'b0;
      next_q        <= 1'b0;
      select_q      <= 1'b0;
      seek          <= 1'b0;
    end else begin
      next_q   <= next_in;
      select_q <= select_in;
      if (abort) begin
        state        <= S_IDLE;
        choice_valid <= 1'b0;
        player       <= '0;
        cursor       <= '0;
        seek         <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              if (low_found) begin
                state  <= S_BROWSE;
                cursor <= low_idx;
              end else begin
                state <= S_DONE;
              end
            end
          end
          S_BROWSE: begin
            if (!low_found) begin
              state <= S_DONE;
              seek  <= 1'b0;
            end else if (seek) begin
              cursor <= low_idx;
              seek   <= 1'b0;
            end else if (take) begin
              state         <= S_COMMIT;
              choice        <= cursor;
              choice_player <= player;
              choice_valid  <= 1'b1;
            end else if (nxt_e && !sel_e) begin
              cursor <= nxt_idx;
            end
          end
          S_COMMIT: begin
            if (ack) begin
              choice_valid <= 1'b0;
              player       <= (player == PW'(N_PLAYERS - 1)) ? '0 : player + 1'b1;
              state        <= S_BROWSE;
              seek         <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_turn_select_ctrl.sv
// tb/tb_turn_select_ctrl.sv - directed scoreboard bench for turn_select_ctrl
module tb_turn_select_ctrl;

  localparam int N  = 9;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         next_in = 1'b0;
  logic         select_in = 1'b0;
  logic [N-1:0] avail_mask = '0;
  logic         ack = 1'b0;
  logic         sel_enable;
  logic [3:0]   cursor;
  logic [0:0]   player;
  logic         choice_valid;
  logic [3:0]   choice;
  logic [0:0]   choice_player;
  logic         no_moves;

  typedef struct packed {
    logic [3:0] c;
    logic [0:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  turn_select_ctrl #(.N_OPTIONS(N), .N_PLAYERS(2), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .next_in(next_in), .select_in(select_in), .avail_mask(avail_mask), .ack(ack),
    .sel_enable(sel_enable), .cursor(cursor), .player(player),
    .choice_valid(choice_valid), .choice(choice), .choice_player(choice_player),
    .no_moves(no_moves)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_next();
    next_in = 1'b1;
    tick();
    next_in = 1'b0;
    tick();
  endtask

  task automatic pulse_sel();
    select_in = 1'b1;
    tick();
    select_in = 1'b0;
    tick();
  endtask

  task automatic push_exp(input logic [3:0] c, input logic [0:0] p);
    exp_t e;
    e.c = c;
    e.p = p;
    exp_q.push_back(e);
  endtask

  task automatic wait_commit(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (choice_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, choice_valid, 1);
    chk({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_choice"}, choice, e.c);
      chk({tag, "_player"}, choice_player, e.p);
    end
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    // Reset, with start asserted to confirm it is ignored
    start = 1'b1;
    tick();
    tick();
    chk("rst_sel_enable", sel_enable, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_player", player, 0);
    chk("rst_valid", choice_valid, 0);
    chk("rst_choice", choice, 0);
    chk("rst_choice_player", choice_player, 0);
    chk("rst_no_moves", no_moves, 0);
    start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", sel_enable, 0);

`ifdef TURN_TIMEOUT_EN
    avail_mask = 9'h1FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (TO - 1) tick();
    chk("to_not_yet", choice_valid, 0);
    push_exp(4'd0, 1'b0);
    tick();
    wait_commit("to_commit");
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif

    // Stepping through a fully free board
    avail_mask = 9'h1FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("browse_sel_enable", sel_enable, 1);
    chk("browse_cursor0", cursor, 0);
    for (int i = 1; i <= 3; i++) begin
      pulse_next();
      chk($sformatf("step_cursor%0d", i), cursor, i);
    end
    next_in = 1'b1;
    repeat (20) tick();
    next_in = 1'b0;
    tick();
    chk("held_next_one_step", cursor, 4);

    // Wrap and skip over occupied cells
    avail_mask = 9'b1_0000_0101;
    pulse_next();
    chk("skip_to_8", cursor, 8);
    pulse_next();
    chk("wrap_to_0", cursor, 0);
    pulse_next();
    chk("skip_to_2", cursor, 2);
    avail_mask = 9'b1_0000_0001;
    pulse_sel();
    chk("occupied_sel_no_commit", choice_valid, 0);
    chk("occupied_sel_browse", sel_enable, 1);
    chk("occupied_sel_cursor", cursor, 2);
    avail_mask = 9'b1_0000_0101;
    tick();

    // Commit, hold without ack, then ack and rotate
    push_exp(4'd2, 1'b0);
    pulse_sel();
    wait_commit("commit_c2");
    repeat (5) tick();
    chk("hold_valid", choice_valid, 1);
    chk("hold_choice", choice, 2);
    chk("commit_sel_enable", sel_enable, 0);
    do_ack();
    chk("ack_valid_drop", choice_valid, 0);
    chk("ack_player_rot", player, 1);
    avail_mask = 9'b1_0001_0000;
    tick();
    chk("ack_lowest_free", cursor, 4);
    chk("ack_back_browse", sel_enable, 1);

    // Simultaneous next and select: select wins
    next_in = 1'b1;
    select_in = 1'b1;
    push_exp(4'd4, 1'b1);
    tick();
    next_in = 1'b0;
    select_in = 1'b0;
    tick();
    wait_commit("both_c4");
    chk("both_cursor_stays", cursor, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", choice_valid, 0);
    chk("abort_idle", sel_enable, 0);
    chk("abort_player", player, 0);
    chk("abort_cursor", cursor, 0);
    do_ack();
    chk("stray_ack_player", player, 0);

    // No free cell at start, then restart from DONE
    avail_mask = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_no_moves", no_moves, 1);
    chk("done_sel_enable", sel_enable, 0);
    avail_mask = 9'b0_0100_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_browse", sel_enable, 1);
    chk("restart_cursor", cursor, 6);
    chk("restart_no_moves", no_moves, 0);
    push_exp(4'd6, 1'b0);
    pulse_sel();
    wait_commit("commit_c6");
    do_ack();
    avail_mask = '0;
    tick();
    chk("board_full_done", no_moves, 1);
    chk("board_full_player", player, 1);
    chk("board_full_valid", choice_valid, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
